// File: rtl/sync_fifo_wr_arb_pkg.sv
// Shared types and index helpers for the sync FIFO write-side arbiter and its picker.
package sync_fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Modular add by explicit compare so non-power-of-2 requester counts wrap correctly.
    function automatic int rr_index(input int base, input int k, input int n);
        int s;
        s = base + k;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int wrap_inc(input int v, input int n);
        return rr_index(v, 1, n);
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_rr_priority_pick.sv
// Round-robin priority pick: first set request at or after rr_ptr, wrapping at NUM_REQ.
module rr_priority_pick
    import sync_fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan from farthest to nearest so the nearest hit is the final assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int c;
            c = rr_index(int'(rr_ptr), k, NUM_REQ);
            if (req[c]) begin
                valid = 1'b1;
                idx   = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module sync_fifo_wr_arb
    import sync_fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [DATA_W-1:0]          fifo_wdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST);

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] beat_cnt;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          own_req;
    logic          accept;
    logic          last_beat;
    logic          end_burst;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    assign busy      = (state == ST_BURST);
    assign own_req   = req[owner];
    assign accept    = busy && own_req && !fifo_full;
    assign last_beat = accept && (req_last[owner] || beat_cnt == BW'(MAX_BURST - 1));
    // A withdrawn request ends the burst without a beat; a full stall does not.
    assign end_burst = busy && (last_beat || !own_req);

    always_comb begin
        gnt        = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        if (accept) begin
            gnt[owner] = 1'b1;
            fifo_wr    = 1'b1;
            fifo_wdata = req_data[int'(owner)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld && !fifo_full) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (accept && !last_beat)
                        beat_cnt <= beat_cnt + 1'b1;
                    if (end_burst) begin
                        state  <= ST_IDLE;
                        rr_ptr <= IW'(wrap_inc(int'(owner), NUM_REQ));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Randomized bench: producer models drive the arbiter, a burst-level model predicts writes.
module tb_sync_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    gnt;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_wdata;
    logic            busy;
    logic [1:0]      owner;

    sync_fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  g;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Producer state: beats left in the current packet and the beat on offer.
    int           p_left[N];
    logic [DW-1:0] p_data[N];
    bit           drop[N];
    bit           rand_mode  = 0;
    int           full_force = 0;
    int           full_pct   = 0;

    // Reference model state.
    bit  m_busy;
    int  m_owner, m_ptr, m_cnt;
    bit  exp_busy;
    int  exp_owner;
    bit  acc_pending;
    int  acc_i;
    bit  chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        exp_busy = 0; exp_owner = 0; acc_pending = 0;
        sb_q.delete();
    endtask

    // Evaluate one cycle from the currently driven inputs; result takes effect at the next edge.
    task automatic model_eval();
        logic [N-1:0] one;
        bit found;
        one = 1;
        exp_busy = m_busy;
        exp_owner = m_owner;
        acc_pending = 0;
        if (!m_busy) begin
            if (req != 0 && !fifo_full) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found = 1;
                        m_owner = c;
                    end
                end
                m_busy = 1;
                m_cnt = 0;
            end
        end else if (req[m_owner] && !fifo_full) begin
            acc_pending = 1;
            acc_i = m_owner;
            sb_q.push_back('{g: one << m_owner, d: p_data[m_owner]});
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_ptr = (m_owner + 1) % N;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc_pending && p_left[acc_i] > 0) begin
            p_left[acc_i]--;
            p_data[acc_i] = DW'($urandom);
        end
        acc_pending = 0;
        for (int i = 0; i < N; i++) begin
            drop[i] = 0;
            if (rand_mode) begin
                if (p_left[i] == 0 && $urandom_range(0, 3) == 0)
                    p_left[i] = $urandom_range(1, 7);
                drop[i] = ($urandom_range(0, 15) == 0);
            end
            req[i]      = (p_left[i] > 0) && !drop[i];
            req_last[i] = (p_left[i] == 1);
            req_data[i*DW +: DW] = p_data[i];
        end
        if (full_force >= 0) fifo_full = full_force[0];
        else fifo_full = ($urandom_range(0, 99) < full_pct);
        #1;
        model_eval();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (fifo_wr) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("gnt", int'(gnt), int'(e.g));
                    chk("wdata", int'(fifo_wdata), int'(e.d));
                end
            end else begin
                chk("idle_gnt", int'(gnt), 0);
                chk("idle_wdata", int'(fifo_wdata), 0);
            end
            chk("busy", int'(busy), int'(exp_busy));
            chk("owner", int'(owner), exp_owner);
        end
    end

    initial begin
        bit hit;
        reset_n = 0;
        req = '0; req_data = '0; req_last = '0; fifo_full = 0;
        for (int i = 0; i < N; i++) begin
            p_left[i] = 0;
            p_data[i] = DW'($urandom);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_wr", int'(fifo_wr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_wdata", int'(fifo_wdata), 0);
        reset_n = 1;
        #1;
        model_eval();
        chk_en = 1;

        // Single producer, 3-beat packet.
        p_left[1] = 3;
        steps(8);
        // All producers with long packets: forced rotation every MAX_BURST beats.
        for (int i = 0; i < N; i++) p_left[i] = 100;
        steps(40);
        for (int i = 0; i < N; i++) p_left[i] = 0;
        steps(3);
        // Backpressure mid-burst.
        full_force = -1; full_pct = 30;
        for (int i = 0; i < N; i++) p_left[i] = 9;
        steps(60);
        // Full while idle holds off the grant.
        full_force = 0;
        for (int i = 0; i < N; i++) p_left[i] = 0;
        steps(4);
        full_force = 1;
        p_left[2] = 2;
        steps(5);
        full_force = 0;
        steps(6);

        // Random traffic.
        rand_mode = 1; full_force = -1; full_pct = 20;
        steps(2000);

        // Reset in the middle of an active burst.
        hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            step();
            hit = exp_busy && acc_pending;
        end
        chk("reset_window_found", int'(hit), 1);
        chk_en = 0;
        #1 reset_n = 0;
        #1;
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_wr", int'(fifo_wr), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_owner", int'(owner), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        #1;
        model_eval();
        chk_en = 1;
        steps(300);

        // Drain and confirm every predicted write appeared.
        rand_mode = 0; full_force = 0;
        for (int i = 0; i < N; i++) p_left[i] = 0;
        steps(10);
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
